// File: rtl/conv_kxk_mac_if.sv
// conv_kxk_mac_if: window-in / result-out valid-ready bus for conv_kxk_mac
interface conv_kxk_mac_if #(
  parameter int K  = 5,
  parameter int DW = 9,
  parameter int BW = 9,
  parameter int OW = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [K*K*DW-1:0] x_win;
  logic [K*K*DW-1:0] w_win;
  logic [BW-1:0]     bias;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  modport master (
    output in_valid, x_win, w_win, bias, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, x_win, w_win, bias, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_kxk_mac.sv
// conv_kxk_mac: column-serial KxK signed MAC with bias, >>>FRAC and OW-bit saturation
// Optional ReLU after saturation when CONV_KXK_RELU_EN is defined.
module conv_kxk_mac #(
  parameter int K    = 5,
  parameter int DW   = 9,
  parameter int BW   = 9,
  parameter int OW   = 9,
  parameter int FRAC = 0
) (
  input logic            clk,
  input logic            rstn,
  conv_kxk_mac_if.slave  bus
);
  localparam int AW  = 2*DW + $clog2(K*K) + 1;
  localparam int MW0 = AW > BW ? AW : BW;
  localparam int SW  = (MW0 > OW ? MW0 : OW) + 1;
  localparam int CW  = $clog2(K);
  localparam int XW  = K*K*DW;
  localparam logic signed [SW-1:0] OMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d, w_q, w_d;
  logic signed [BW-1:0]  bias_q, bias_d;
  logic signed [AW-1:0]  acc_q, acc_d, col_sum;
  logic [CW-1:0]         col_q, col_d;
  logic signed [OW-1:0]  out_q, out_d, sat, res;
  logic signed [SW-1:0]  sum, shf;
  logic signed [2*DW-1:0] prod [K];

  // The captured window shifts down one column per MAC cycle, so column 0 is always the live one.
  always_comb begin
    col_sum = '0;
    for (int r = 0; r < K; r++) begin
      prod[r] = $signed(x_q[r*DW +: DW]) * $signed(w_q[r*DW +: DW]);
      col_sum = col_sum + {{(AW-2*DW){prod[r][2*DW-1]}}, prod[r]};
    end
  end

  always_comb begin
    sum = {{(SW-AW){acc_q[AW-1]}}, acc_q} + {{(SW-BW){bias_q[BW-1]}}, bias_q};
    shf = sum >>> FRAC;
    sat = shf > OMAX ? OMAX[OW-1:0] : shf < OMIN ? OMIN[OW-1:0] : shf[OW-1:0];
`ifdef CONV_KXK_RELU_EN
    res = sat[OW-1] ? '0 : sat;
`else
    res = sat;
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    col_d   = col_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        x_d     = bus.x_win;
        w_d     = bus.w_win;
        bias_d  = bus.bias;
        acc_d   = '0;
        col_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_q + col_sum;
        x_d     = x_q >> (K*DW);
        w_d     = w_q >> (K*DW);
        col_d   = col_q + 1'b1;
        state_d = col_q == CW'(K-1) ? FIN : MAC;
      end
      FIN: begin
        out_d   = res;
        state_d = OUT;
      end
      OUT: state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      x_q     <= '0;
      w_q     <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      col_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      col_q   <= col_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_conv_kxk_mac.sv
// tb_conv_kxk_mac: directed checks of conv_kxk_mac, FRAC=0 and FRAC=2 instances fed the same stimulus
module tb_conv_kxk_mac;
  localparam int K  = 5;
  localparam int DW = 9;
  localparam int XW = K*K*DW;

  logic clk = 0, rstn = 0, in_valid = 0, out_ready = 1;
  logic [XW-1:0] x_win = '0, w_win = '0, xm, wm;
  logic [8:0] bias = '0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  conv_kxk_mac_if #(.K(K), .DW(DW), .BW(9), .OW(9)) if0 ();
  conv_kxk_mac_if #(.K(K), .DW(DW), .BW(9), .OW(9)) if2 ();

  assign if0.in_valid = in_valid;
  assign if0.x_win = x_win;
  assign if0.w_win = w_win;
  assign if0.bias = bias;
  assign if0.out_ready = out_ready;
  assign if2.in_valid = in_valid;
  assign if2.x_win = x_win;
  assign if2.w_win = w_win;
  assign if2.bias = bias;
  assign if2.out_ready = out_ready;

  conv_kxk_mac #(.K(K), .DW(DW), .BW(9), .OW(9), .FRAC(0)) u0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  conv_kxk_mac #(.K(K), .DW(DW), .BW(9), .OW(9), .FRAC(2)) u2 (.clk(clk), .rstn(rstn), .bus(if2.slave));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [XW-1:0] fill(input int v);
    logic [XW-1:0] f;
    for (int i = 0; i < K*K; i++) f[i*DW +: DW] = DW'(v);
    return f;
  endfunction

  function automatic int relu(input int v);
`ifdef CONV_KXK_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Latency n counts the accept edge as edge 1; out_valid must be seen after edge K+2.
  task automatic run(input string tag, input logic [XW-1:0] xv, input logic [XW-1:0] wv,
                     input int b, input int e0, input int e2, input bit stall);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, int'(if0.in_ready & if2.in_ready), 1);
    x_win = xv;
    w_win = wv;
    bias = 9'(b);
    in_valid = 1;
    out_ready = !stall;
    @(posedge clk);
    #1;
    in_valid = 0;
    x_win = '0;
    w_win = '0;
    bias = '0;
    n = 1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!(if0.out_valid && if2.out_valid) && n < 20);
    check({tag, "_latency"}, n, K+2);
    check({tag, "_data_f0"}, $signed(if0.out_data), relu(e0));
    check({tag, "_data_f2"}, $signed(if2.out_data), relu(e2));
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        in_valid = i[0];
        x_win = fill(2);
        w_win = fill(2);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_data"}, $signed(if0.out_data), relu(e0));
        check({tag, "_hold_in_ready"}, int'(if0.in_ready), 0);
        check({tag, "_hold_valid"}, int'(if0.out_valid), 1);
      end
      in_valid = 0;
      out_ready = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, int'(if0.out_valid | if2.out_valid), 0);
    check({tag, "_back_idle"}, int'(if0.in_ready & if2.in_ready), 1);
  endtask

  initial begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        xm[(c*K+r)*DW +: DW] = DW'(c);
        wm[(c*K+r)*DW +: DW] = DW'(r - c);
      end
    #12;
    check("rst_in_ready", int'(if0.in_ready), 1);
    check("rst_out_valid", int'(if0.out_valid), 0);
    check("rst_out_data", $signed(if0.out_data), 0);
    @(negedge clk);
    rstn = 1;
    run("ones",  fill(1),   fill(1),     0,   25,   6, 0);
    run("neg",   fill(-1),  fill(1),    -3,  -28,  -7, 0);
    run("satp",  fill(255), fill(255),   0,  255, 255, 0);
    run("satn",  fill(255), fill(-256),  0, -256, -256, 0);
    run("bias2", fill(1),   fill(1),     2,   27,   6, 0);
    run("negf",  fill(-1),  fill(1),     0,  -25,  -7, 0);
    run("mix",   xm,        wm,          4,  -46, -12, 0);
    run("stall", fill(1),   fill(1),     0,   25,   6, 1);
    run("after", xm,        wm,          4,  -46, -12, 0);
    @(negedge clk);
    x_win = fill(1);
    w_win = fill(1);
    bias = '0;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn = 0;
    #1;
    check("midrst_in_ready", int'(if0.in_ready & if2.in_ready), 1);
    check("midrst_out_valid", int'(if0.out_valid | if2.out_valid), 0);
    check("midrst_out_data", $signed(if0.out_data), 0);
    @(negedge clk);
    rstn = 1;
    run("post_rst", fill(1), fill(1), 0, 25, 6, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
